// File: rtl/bcd_seg_display.sv
// Captures a 4-digit packed BCD value on rdy and time-multiplexes it onto a
// common-anode 7-segment display with optional leading-zero blanking.
module bcd_seg_display #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic [15:0] bcd_d_in,
    input  logic        blank_lz,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        err,
    output logic        frame_tick
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {DIG0, DIG1, DIG2, DIG3} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [15:0]      disp;
    logic             nib_err;
    logic             cnt_wrap;
    logic [3:0]       nib;
    logic [3:0]       blank;
    logic [1:0]       idx;
    logic [6:0]       seg_nxt;
    logic [3:0]       an_nxt;
    logic             frame_tick_nxt;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    assign nib_err = (bcd_d_in[3:0]   > 4'd9) | (bcd_d_in[7:4]   > 4'd9) |
                     (bcd_d_in[11:8]  > 4'd9) | (bcd_d_in[15:12] > 4'd9);

    // Capture register and its validity flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp <= 16'h0000;
            err  <= 1'b0;
        end else if (rdy) begin
            disp <= bcd_d_in;
            err  <= nib_err;
        end
    end

    // A slot is blanked only when it and every slot above it hold zero
    assign blank[3] = blank_lz && (disp[15:12] == 4'd0);
    assign blank[2] = blank[3] && (disp[11:8] == 4'd0);
    assign blank[1] = blank[2] && (disp[7:4] == 4'd0);
    assign blank[0] = 1'b0;

    assign idx      = state;
    assign cnt_wrap = (cnt == CNT_MAX);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + CNT_W'(1);
        nib            = 4'd0;
        seg_nxt        = 7'h7F;
        an_nxt         = 4'hF;
        frame_tick_nxt = 1'b0;

        if (cnt_wrap) begin
            cnt_nxt = '0;
            case (state)
                DIG0:    state_nxt = DIG1;
                DIG1:    state_nxt = DIG2;
                DIG2:    state_nxt = DIG3;
                default: state_nxt = DIG0;
            endcase
        end

        case (state)
            DIG0:    nib = disp[3:0];
            DIG1:    nib = disp[7:4];
            DIG2:    nib = disp[11:8];
            default: nib = disp[15:12];
        endcase

        if (!blank[idx]) begin
            seg_nxt     = decode(nib);
            an_nxt[idx] = 1'b0;
        end

        frame_tick_nxt = cnt_wrap && (state == DIG3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= DIG0;
            cnt        <= '0;
            seg        <= 7'h7F;
            an         <= 4'hF;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= frame_tick_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_seg_display.sv
// Scoreboard bench for bcd_seg_display: a timeline-based model predicts every
// registered output; a negedge monitor pops and compares.
module tb_bcd_seg_display;

    localparam int unsigned RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] bcd_d_in = 16'h0000;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        err;
    logic        frame_tick;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       ft;
        logic       err;
    } exp_t;

    localparam exp_t RESET_EXP = '{seg: 7'h7F, an: 4'hF, ft: 1'b0, err: 1'b0};

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [15:0] m_disp = 16'h0000;
    logic        m_err = 1'b0;
    int unsigned t = 0;

    bcd_seg_display #(.REFRESH_DIV(RD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .bcd_d_in(bcd_d_in), .blank_lz(blank_lz),
        .seg(seg), .an(an), .err(err), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (d > 4'd9) return 7'h3F;
        return tab[d];
    endfunction

    function automatic logic any_bad(input logic [15:0] v);
        logic bad = 1'b0;
        for (int k = 0; k < 4; k++)
            if (((v >> (4 * k)) & 16'hF) > 16'd9) bad = 1'b1;
        return bad;
    endfunction

    // Output for elapsed-cycle count tt since reset, from the value shown
    function automatic exp_t predict(input logic [15:0] d, input logic bl, input int unsigned tt);
        exp_t        p;
        int          k;
        logic [15:0] sh;
        logic [3:0]  a;
        k  = int'((tt / RD) % 4);
        sh = d >> (4 * k);
        a  = 4'hF;
        if (bl && k != 0 && sh == 16'h0000) begin
            p.seg = 7'h7F;
        end else begin
            p.seg = seg_of(sh[3:0]);
            a[k]  = 1'b0;
        end
        p.an  = a;
        p.ft  = ((tt % RD) == RD - 1) && (k == 3);
        p.err = 1'b0;
        return p;
    endfunction

    always @(posedge clk or posedge rst) begin
        exp_t p;
        if (rst) begin
            t      = 0;
            m_disp = 16'h0000;
            m_err  = 1'b0;
            q.delete();
        end else begin
            p = predict(m_disp, blank_lz, t);
            if (rdy) begin
                m_disp = bcd_d_in;
                m_err  = any_bad(bcd_d_in);
            end
            p.err = m_err;
            q.push_back(p);
            t++;
        end
    end

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h want %h", name, $time, act, req);
        end
    endtask

    task automatic check_all(input exp_t e);
        cmp("seg", seg, e.seg);
        cmp("an", 7'(an), 7'(e.an));
        cmp("frame_tick", 7'(frame_tick), 7'(e.ft));
        cmp("err", 7'(err), 7'(e.err));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) e = q.pop_front();
        else              e = RESET_EXP;
        check_all(e);
    end

    function automatic logic [15:0] rnd_bcd();
        logic [15:0] v = 16'h0000;
        int unsigned r;
        for (int k = 0; k < 4; k++) begin
            r = $urandom % 8;
            if (r >= 7)      v = v | (16'(10 + $urandom % 6) << (4 * k));
            else if (r >= 4) v = v | (16'($urandom % 10) << (4 * k));
        end
        return v;
    endfunction

    task automatic load(input logic [15:0] v, input logic bl, input int hold);
        @(negedge clk);
        rdy = 1'b1; bcd_d_in = v; blank_lz = bl;
        @(negedge clk);
        rdy = 1'b0; bcd_d_in = 16'($urandom);
        repeat (hold) @(negedge clk);
    endtask

    task automatic mid_reset(input logic with_rdy);
        @(posedge clk);
        #2;
        rst = 1'b1;
        rdy = with_rdy;
        bcd_d_in = 16'h9999;
        #1;
        check_all(RESET_EXP);
        @(negedge clk);
        #2;
        rst = 1'b0;
        rdy = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (21) @(negedge clk);
        mid_reset(1'b0);
        repeat (40) @(negedge clk);

        load(16'h1234, 1'b0, 20);
        load(16'h0025, 1'b1, 20);
        blank_lz = 1'b0;
        repeat (18) @(negedge clk);
        load(16'h0000, 1'b1, 18);
        load(16'h0A05, 1'b1, 18);

        @(negedge clk);
        rdy = 1'b1;
        for (int i = 1; i <= 24; i++) begin
            bcd_d_in = 16'(i % 10) | (16'(i / 10) << 4);
            @(negedge clk);
        end
        rdy = 1'b0;
        repeat (4) @(negedge clk);

        mid_reset(1'b1);
        repeat (20) @(negedge clk);

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            rdy      = ($urandom % 6) == 0;
            bcd_d_in = rnd_bcd();
            if (($urandom % 16) == 0) blank_lz = ~blank_lz;
            if (($urandom % 150) == 0) mid_reset(($urandom % 2) == 1);
        end
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_seg_display.md
# bcd_seg_display

Downstream consumer of the binary-to-BCD converter. It captures the 16-bit, 4-digit packed BCD result whenever the converter pulses `rdy`, then time-multiplexes the four digits onto a common-anode 7-segment display. It provides optional leading-zero blanking, flags any non-decimal nibble, and emits a frame marker once per full scan.

## Interface
Parameters:
- `REFRESH_DIV`, default 100000: clock cycles each digit stays lit; legal range 2..2^20; one full scan takes 4*REFRESH_DIV cycles.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  capture strobe from the BCD converter; level-sampled every edge.
- `bcd_d_in`  in  16  packed BCD: [3:0] ones, [7:4] tens, [11:8] hundreds, [15:12] thousands.
- `blank_lz`  in  1  1 = blank leading zeros.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `an`  out  4  digit anodes, active-low; an[0] = ones digit.
- `err`  out  1  1 while the held value contains a nibble > 9.
- `frame_tick`  out  1  one-cycle pulse at each scan wrap.

## Operation
- Holding register `disp` (16 b): at any edge with `rdy`=1, `disp <= bcd_d_in`. Otherwise it holds. If `rdy` stays high, capture repeats every cycle.
- `err` is registered alongside the capture: `err <= |{nibble_k > 9}` of `bcd_d_in`. It changes only on capture.
- Refresh counter `cnt` (ceil(log2(REFRESH_DIV)) bits) counts 0..REFRESH_DIV-1 and then wraps to 0.
- Digit index `idx` (2 b) increments when `cnt`==REFRESH_DIV-1 and wraps 3 -> 0.
- Scan states are the `idx` values, always in the order 0 -> 1 -> 2 -> 3 -> 0. No other states exist.
- Registered outputs each edge, computed from current `idx` and `disp`:
  - `an`: all ones except bit `idx` = 0, unless the slot is blanked (then `an` = 4'b1111).
  - `seg`: decode of nibble `idx`, or 7'h7F when the slot is blanked.
- Decode table (gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10. Nibbles A..F decode to a dash, 3F.
- Blanking, evaluated live from `blank_lz` and `disp`: slot k ∈ {1,2,3} is blanked when `blank_lz`=1 and nibbles k..3 are all 0. Slot 0 is never blanked, so a value of 0 shows "0".
- A dash nibble counts as non-zero and suppresses blanking of every slot below it.
- `frame_tick` is registered: it is 1 in the cycle after the edge where `cnt`==REFRESH_DIV-1 and `idx`==3, and 0 otherwise.

## Timing
- Reset (async assert, any cycle):
  - `disp`=0, `err`=0, `cnt`=0, `idx`=0.
  - `seg`=7'h7F, `an`=4'hF, `frame_tick`=0, all immediately.
- First edge after reset release: `an`=1110, `seg`=40 (digit 0 shows "0").
- Capture-to-display latency:
  - Value at edge N with `rdy`=1 is in `disp` after edge N.
  - The lit digit reflects it from edge N+1.
  - `err` is valid after edge N.
- Digit k's output is held for exactly REFRESH_DIV consecutive cycles, registered one cycle after `idx` becomes k.
- `rst` and `rdy` in the same cycle: reset wins; nothing is captured.
- Reset mid-scan: the scan restarts at digit 0 with `cnt`=0.
- `rdy` mid-digit: `cnt` and `idx` are undisturbed; the new value shows on the current slot from the next edge.
- `blank_lz` change takes effect on the next registered output.

## Test plan
REFRESH_DIV=4 for all cases.
1. Assert `rst` mid-scan -> `seg`=7F, `an`=F, `err`=0 asynchronously. Release -> next edge `an`=1110, `seg`=40. `an` steps 1101, 1011, 0111 every 4 cycles. `frame_tick` pulses once every 16 cycles.
2. `rdy` pulse with `bcd_d_in`=16'h1234, `blank_lz`=0 -> over one scan, slots 0..3 show `seg`=19, 30, 24, 79. `err`=0.
3. `bcd_d_in`=16'h0025, `blank_lz`=1 -> slots 3 and 2 give `an`=1111 and `seg`=7F; slot 1 shows 24; slot 0 shows 12. Set `blank_lz`=0 -> slots 3 and 2 show 40.
4. `bcd_d_in`=16'h0000, `blank_lz`=1 -> only slot 0 lit with `seg`=40. `bcd_d_in`=16'h0A05 -> slot 2 shows 3F, slot 1 shows 40 (not blanked), `err`=1.
5. `rdy` held high while `bcd_d_in` increments 16'h0001 -> 16'h0002 each cycle -> `seg` tracks the latest value with 1-cycle lag. The scan cadence is unchanged.
6. `rst` and `rdy` asserted together with `bcd_d_in`=16'h9999 -> `disp` stays 0, and after release digit 0 shows 40.
